nmea_field_parser: RTL and testbench
====================================

NMEA_FIELD_PARSER -- requirements
Module: nmea_field_parser

Interface
REQ-001 Parameter MAX_FIELDS, 8, SHALL set the maximum number of data fields emitted per sentence.
REQ-002 Parameter FIELD_BYTES, 12, SHALL set the maximum number of characters stored per field.
REQ-003 Parameter SENTENCE_ID, 24'h474C4C ("GLL"), SHALL set the 3-char sentence type accepted (address chars 3..5).
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 i_Rx_DV  in  1  SHALL be the one-cycle byte-valid strobe from the UART receiver.
REQ-007 i_Rx_Byte  in  8  SHALL be the received ASCII byte, sampled only when i_Rx_DV=1.
REQ-008 o_field_valid  out  1  SHALL be a one-cycle pulse marking a completed field.
REQ-009 o_field_idx  out  $clog2(MAX_FIELDS)  SHALL be the 0-based field index; field 0 is the first field after the address.
REQ-010 o_field_len  out  $clog2(FIELD_BYTES+1)  SHALL be the number of stored characters (0 for an empty field).
REQ-011 o_field_data  out  8*FIELD_BYTES  SHALL hold the field: char k at bits [8k+7:8k], unused bytes zero.
REQ-012 o_field_trunc  out  1  SHALL flag, with o_field_valid, that the field exceeded FIELD_BYTES.
REQ-013 o_sentence_done  out  1  SHALL be a one-cycle pulse at sentence end.
REQ-014 o_cksum_ok  out  1  SHALL be valid with o_sentence_done; 1 = received checksum matches computed one.
REQ-015 o_field_count  out  $clog2(MAX_FIELDS+1)  SHALL be valid with o_sentence_done; number of fields emitted.
REQ-016 o_overflow  out  1  SHALL be valid with o_sentence_done; 1 = more than MAX_FIELDS fields arrived.

Function
REQ-017 States SHALL be IDLE, ADDR, FIELD, CK_HI, CK_LO; bytes are consumed only on i_Rx_DV=1.
REQ-018 IDLE -> ADDR on '$' (0x24); all other bytes ignored.
REQ-019 ADDR SHALL collect 5 chars; on the ',' after the 5th, compare chars 3..5 to SENTENCE_ID: match -> FIELD, mismatch or any other terminator -> IDLE with no outputs.
REQ-020 Running XOR checksum SHALL cover every byte after '$' up to but excluding '*'.
REQ-021 In FIELD, ',' or '*' SHALL terminate the current field; o_field_valid SHALL assert the cycle after the terminating byte's i_Rx_DV.
REQ-022 Characters beyond FIELD_BYTES SHALL be dropped, length saturates at FIELD_BYTES, o_field_trunc=1.
REQ-023 Fields with index >= MAX_FIELDS SHALL not be emitted and SHALL set the overflow flag; checksum still accumulates.
REQ-024 '*' SHALL move FIELD -> CK_HI; two hex digits (0-9, A-F, a-f) SHALL be captured in CK_HI, CK_LO.
REQ-025 o_sentence_done SHALL assert the cycle after the second checksum digit's i_Rx_DV, then -> IDLE; a non-hex digit SHALL force o_cksum_ok=0.
REQ-026 '$' received in any state SHALL abort the current sentence without o_sentence_done and restart ADDR with cleared checksum/field state.
REQ-027 CR (0x0D) or LF (0x0A) in ADDR or FIELD SHALL abort to IDLE without o_sentence_done; CR/LF in IDLE are ignored.
REQ-028 o_field_data, idx, len, trunc SHALL hold their values until the next o_field_valid; done-qualified outputs hold until the next o_sentence_done.

Reset
REQ-029 While rst=0: state IDLE, all outputs 0, checksum, counters and field buffer cleared, asynchronously.
REQ-030 Reset mid-sentence SHALL discard it; after release, the parser SHALL require a fresh '$'.

Structure
REQ-031 Package nmea_pkg SHALL hold ASCII constants ('$', ',', '*', CR, LF) and the state encoding.
REQ-032 Sub-module nmea_hex_nibble SHALL convert one ASCII char to a 4-bit value plus valid flag.

Verification
REQ-033 "$GPGLL,1,N*2F\r\n" -> field0 "1" len1, field1 "N" len1, done with cksum_ok=1, field_count=2, overflow=0.
REQ-034 "$GPGLL,1,N*30\r\n" -> same fields, done with cksum_ok=0.
REQ-035 "$GPGGA,1,N*2F" -> no field_valid, no done.
REQ-036 GLL with 13-char field, FIELD_BYTES=12 -> len=12, first 12 chars stored, trunc=1.
REQ-037 "$GPGLL,1,N" then "$GPGLL,,N*xx" with correct checksum -> no done for first; second gives field0 len0, done cksum_ok=1.
REQ-038 10 fields with MAX_FIELDS=8 -> 8 field_valid pulses, done with field_count=8, overflow=1; rst=0 mid-field -> outputs 0, no done.

Source files
------------

// File: rtl/nmea_pkg.sv
// Shared ASCII framing constants and parser state encoding for the NMEA field parser.
package nmea_pkg;

  localparam logic [7:0] ASCII_DOLLAR = 8'h24;
  localparam logic [7:0] ASCII_COMMA  = 8'h2C;
  localparam logic [7:0] ASCII_STAR   = 8'h2A;
  localparam logic [7:0] ASCII_CR     = 8'h0D;
  localparam logic [7:0] ASCII_LF     = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    FIELD,
    CK_HI,
    CK_LO
  } nmea_state_t;

endpackage

// File: rtl/nmea_hex_nibble.sv
// Converts one ASCII hex character (0-9, A-F, a-f) to its 4-bit value plus a valid flag.
module nmea_hex_nibble (
  input  logic [7:0] ch,
  output logic [3:0] nibble,
  output logic       valid
);

  always_comb begin
    nibble = '0;
    valid  = 1'b0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      nibble = ch[3:0];
      valid  = 1'b1;
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      nibble = ch[3:0] + 4'd9;
      valid  = 1'b1;
    end
  end

endmodule

// File: rtl/nmea_field_parser.sv
// Byte-stream NMEA sentence parser: filters on sentence type, emits comma-separated
// fields one at a time and reports the XOR checksum result at sentence end.
module nmea_field_parser
  import nmea_pkg::*;
#(
  parameter int unsigned MAX_FIELDS  = 8,
  parameter int unsigned FIELD_BYTES = 12,
  parameter logic [23:0] SENTENCE_ID = 24'h474C4C
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_Rx_DV,
  input  logic [7:0]                       i_Rx_Byte,
  output logic                             o_field_valid,
  output logic [$clog2(MAX_FIELDS)-1:0]    o_field_idx,
  output logic [$clog2(FIELD_BYTES+1)-1:0] o_field_len,
  output logic [8*FIELD_BYTES-1:0]         o_field_data,
  output logic                             o_field_trunc,
  output logic                             o_sentence_done,
  output logic                             o_cksum_ok,
  output logic [$clog2(MAX_FIELDS+1)-1:0]  o_field_count,
  output logic                             o_overflow
);

  localparam int unsigned IDX_W  = $clog2(MAX_FIELDS);
  localparam int unsigned LEN_W  = $clog2(FIELD_BYTES+1);
  localparam int unsigned CNT_W  = $clog2(MAX_FIELDS+1);
  localparam int unsigned DATA_W = 8*FIELD_BYTES;
  localparam int unsigned SEL_W  = $clog2(DATA_W);

  nmea_state_t       state;
  logic [2:0]        addr_cnt;
  logic [23:0]       addr_id;
  logic [7:0]        cksum;
  logic [DATA_W-1:0] cur_data;
  logic [LEN_W-1:0]  cur_len;
  logic              cur_trunc;
  logic [CNT_W-1:0]  field_cnt;
  logic              ovf;
  logic [3:0]        ck_hi;
  logic              ck_hi_ok;

  logic [3:0]        hex_val;
  logic              hex_ok;
  logic [SEL_W-1:0]  wr_sel;
  logic              is_eol;
  logic              is_term;
  logic              field_room;
  logic              field_full;

  nmea_hex_nibble u_hex (
    .ch     (i_Rx_Byte),
    .nibble (hex_val),
    .valid  (hex_ok)
  );

  assign wr_sel     = SEL_W'({cur_len, 3'b000});
  assign is_eol     = (i_Rx_Byte == ASCII_CR) || (i_Rx_Byte == ASCII_LF);
  assign is_term    = (i_Rx_Byte == ASCII_COMMA) || (i_Rx_Byte == ASCII_STAR);
  assign field_room = (field_cnt < CNT_W'(MAX_FIELDS));
  assign field_full = (cur_len >= LEN_W'(FIELD_BYTES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      addr_cnt        <= '0;
      addr_id         <= '0;
      cksum           <= '0;
      cur_data        <= '0;
      cur_len         <= '0;
      cur_trunc       <= 1'b0;
      field_cnt       <= '0;
      ovf             <= 1'b0;
      ck_hi           <= '0;
      ck_hi_ok        <= 1'b0;
      o_field_valid   <= 1'b0;
      o_field_idx     <= '0;
      o_field_len     <= '0;
      o_field_data    <= '0;
      o_field_trunc   <= 1'b0;
      o_sentence_done <= 1'b0;
      o_cksum_ok      <= 1'b0;
      o_field_count   <= '0;
      o_overflow      <= 1'b0;
    end else begin
      o_field_valid   <= 1'b0;
      o_sentence_done <= 1'b0;
      if (i_Rx_DV) begin
        // '$' restarts from any state, so it is handled ahead of the state decode.
        if (i_Rx_Byte == ASCII_DOLLAR) begin
          state     <= ADDR;
          addr_cnt  <= '0;
          addr_id   <= '0;
          cksum     <= '0;
          cur_data  <= '0;
          cur_len   <= '0;
          cur_trunc <= 1'b0;
          field_cnt <= '0;
          ovf       <= 1'b0;
          ck_hi     <= '0;
          ck_hi_ok  <= 1'b0;
        end else begin
          case (state)
            IDLE: ;
            ADDR: begin
              cksum <= cksum ^ i_Rx_Byte;
              if (is_eol) begin
                state <= IDLE;
              end else if (addr_cnt == 3'd5) begin
                // Shift register holds the last three address chars, i.e. chars 3..5.
                state <= (i_Rx_Byte == ASCII_COMMA && addr_id == SENTENCE_ID) ? FIELD : IDLE;
              end else if (i_Rx_Byte == ASCII_COMMA) begin
                state <= IDLE;
              end else begin
                addr_id  <= {addr_id[15:0], i_Rx_Byte};
                addr_cnt <= addr_cnt + 3'd1;
              end
            end
            FIELD: begin
              if (is_eol) begin
                state <= IDLE;
              end else if (is_term) begin
                if (i_Rx_Byte == ASCII_COMMA) cksum <= cksum ^ i_Rx_Byte;
                else                          state <= CK_HI;
                if (field_room) begin
                  o_field_valid <= 1'b1;
                  o_field_idx   <= field_cnt[IDX_W-1:0];
                  o_field_len   <= cur_len;
                  o_field_data  <= cur_data;
                  o_field_trunc <= cur_trunc;
                  field_cnt     <= field_cnt + 1'b1;
                end else begin
                  ovf <= 1'b1;
                end
                cur_data  <= '0;
                cur_len   <= '0;
                cur_trunc <= 1'b0;
              end else begin
                cksum <= cksum ^ i_Rx_Byte;
                if (field_full) begin
                  cur_trunc <= 1'b1;
                end else begin
                  cur_data[wr_sel +: 8] <= i_Rx_Byte;
                  cur_len               <= cur_len + 1'b1;
                end
              end
            end
            CK_HI: begin
              ck_hi    <= hex_val;
              ck_hi_ok <= hex_ok;
              state    <= CK_LO;
            end
            CK_LO: begin
              o_sentence_done <= 1'b1;
              o_cksum_ok      <= ck_hi_ok && hex_ok && ({ck_hi, hex_val} == cksum);
              o_field_count   <= field_cnt;
              o_overflow      <= ovf;
              state           <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_nmea_field_parser.sv
// Self-checking bench for nmea_field_parser: sentence table plus hand-written abort/reset sequences,
// with field and sentence-done expectations checked through scoreboard queues.
module tb_nmea_field_parser;

  localparam int MF = 8;
  localparam int FB = 12;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 dv  = 1'b0;
  logic [7:0]           rx  = 8'h00;
  logic                 o_field_valid;
  logic [2:0]           o_field_idx;
  logic [3:0]           o_field_len;
  logic [8*FB-1:0]      o_field_data;
  logic                 o_field_trunc;
  logic                 o_sentence_done;
  logic                 o_cksum_ok;
  logic [3:0]           o_field_count;
  logic                 o_overflow;

  nmea_field_parser #(
    .MAX_FIELDS  (MF),
    .FIELD_BYTES (FB),
    .SENTENCE_ID (24'h474C4C)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_Rx_DV         (dv),
    .i_Rx_Byte       (rx),
    .o_field_valid   (o_field_valid),
    .o_field_idx     (o_field_idx),
    .o_field_len     (o_field_len),
    .o_field_data    (o_field_data),
    .o_field_trunc   (o_field_trunc),
    .o_sentence_done (o_sentence_done),
    .o_cksum_ok      (o_cksum_ok),
    .o_field_count   (o_field_count),
    .o_overflow      (o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              idx;
    int              len;
    logic [8*FB-1:0] data;
    bit              trunc;
  } fexp_t;

  typedef struct {
    bit ok;
    int count;
    bit ovf;
  } dexp_t;

  typedef struct {
    string s;
    bit    has_f;
    string f;
    bit    done;
    bit    ok;
    int    cnt;
    bit    ovf;
  } vec_t;

  fexp_t fq[$];
  dexp_t dq[$];
  vec_t  vt[$];
  fexp_t fe;
  dexp_t de;
  int    tests = 0;
  int    fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && o_field_valid) begin
      if (fq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_field: got pulse idx=%0d len=%0d expected none", o_field_idx, o_field_len);
      end else begin
        fe = fq.pop_front();
        check("field_idx", o_field_idx, fe.idx);
        check("field_len", o_field_len, fe.len);
        check("field_data", o_field_data, fe.data);
        check("field_trunc", o_field_trunc, fe.trunc);
      end
    end
    if (rst && o_sentence_done) begin
      if (dq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done count=%0d expected none", o_field_count);
      end else begin
        de = dq.pop_front();
        check("cksum_ok", o_cksum_ok, de.ok);
        check("field_count", o_field_count, de.count);
        check("overflow", o_overflow, de.ovf);
      end
    end
  end

  // Replaces "##" after '*' with the XOR of chars between the latest '$' and '*'.
  function automatic string fix_ck(input string s);
    string r;
    string h;
    byte   x;
    bit    acc;
    r   = s;
    x   = 8'h00;
    acc = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h24) begin
        x   = 8'h00;
        acc = 1'b1;
      end else if (s[i] == 8'h2A && acc) begin
        acc = 1'b0;
        if (i + 2 < s.len() && s[i+1] == 8'h23 && s[i+2] == 8'h23) begin
          h      = $sformatf("%02X", x);
          r[i+1] = h[0];
          r[i+2] = h[1];
        end
      end else if (acc) begin
        x = x ^ s[i];
      end
    end
    return r;
  endfunction

  task automatic push_fields(input string f);
    fexp_t           e;
    int              idx;
    int              k;
    logic [8*FB-1:0] d;
    idx = 0;
    k   = 0;
    d   = '0;
    for (int i = 0; i <= f.len(); i++) begin
      if (i == f.len() || f[i] == 8'h7C) begin
        e.idx   = idx;
        e.len   = (k > FB) ? FB : k;
        e.data  = d;
        e.trunc = (k > FB);
        fq.push_back(e);
        idx++;
        k = 0;
        d = '0;
      end else begin
        if (k < FB) d[8*k +: 8] = f[i];
        k++;
      end
    end
  endtask

  task automatic push_field(input int idx, input int len, input logic [8*FB-1:0] data);
    fexp_t e;
    e.idx   = idx;
    e.len   = len;
    e.data  = data;
    e.trunc = 1'b0;
    fq.push_back(e);
  endtask

  task automatic push_done(input bit ok, input int count, input bit ovf);
    dexp_t d;
    d.ok    = ok;
    d.count = count;
    d.ovf   = ovf;
    dq.push_back(d);
  endtask

  task automatic send_byte(input byte b);
    @(negedge clk);
    dv = 1'b1;
    rx = b;
    @(negedge clk);
    dv = 1'b0;
    rx = 8'h00;
  endtask

  task automatic send_sentence(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic drain(input string name);
    repeat (4) @(negedge clk);
    check({name, "_fields_left"}, fq.size(), 0);
    check({name, "_done_left"}, dq.size(), 0);
  endtask

  task automatic add_vec(input string s, input bit has_f, input string f,
                         input bit done, input bit ok, input int cnt, input bit ovf);
    vec_t v;
    v.s     = s;
    v.has_f = has_f;
    v.f     = f;
    v.done  = done;
    v.ok    = ok;
    v.cnt   = cnt;
    v.ovf   = ovf;
    vt.push_back(v);
  endtask

  initial begin
    add_vec("$GPGLL,1,N*2F\r\n",                1, "1|N",             1, 1, 2, 0);
    add_vec("$GPGLL,1,N*30\r\n",                1, "1|N",             1, 0, 2, 0);
    add_vec("$GPGGA,1,N*2F\r\n",                0, "",                0, 0, 0, 0);
    add_vec("$GPGLL,ABCDEFGHIJKLM,X*##\r\n",    1, "ABCDEFGHIJKLM|X", 1, 1, 2, 0);
    add_vec("$GPGLL,a,b,c,d,e,f,g,h,i,j*##\r\n", 1, "a|b|c|d|e|f|g|h", 1, 1, 8, 1);
    add_vec("$GPGLL,1,N*2f\r\n",                1, "1|N",             1, 1, 2, 0);
    add_vec("$GPGLL,1*zz\r\n",                  1, "1",               1, 0, 1, 0);
    add_vec("$GPGLL,12\r,N*2F\r\n",             0, "",                0, 0, 0, 0);
    add_vec("$GPGL,1*00\r\n",                   0, "",                0, 0, 0, 0);
    add_vec("$GPGLL,5,*##\r\n",                 1, "5|",              1, 1, 2, 0);
    add_vec("xx\n*$GPGLL,7*##\r\n",             1, "7",               1, 1, 1, 0);
    add_vec("$GPGLLX,1*00\r\n",                 0, "",                0, 0, 0, 0);

    #2 rst = 1'b0;
    #5;
    check("reset_flags", {o_field_valid, o_field_idx, o_field_len, o_field_trunc,
                          o_sentence_done, o_cksum_ok, o_field_count, o_overflow}, 0);
    check("reset_data", o_field_data, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < vt.size(); v++) begin
      if (vt[v].has_f) push_fields(vt[v].f);
      if (vt[v].done) push_done(vt[v].ok, vt[v].cnt, vt[v].ovf);
      send_sentence(fix_ck(vt[v].s));
      drain($sformatf("vec%0d", v));
    end

    // Unterminated sentence aborted by a new '$': first field still emitted, no done for it.
    push_field(0, 1, 96'h31);
    push_field(0, 0, 96'h0);
    push_field(1, 1, 96'h4E);
    push_done(1'b1, 2, 1'b0);
    send_sentence(fix_ck("$GPGLL,1,N$GPGLL,,N*##\r\n"));
    drain("abort_restart");

    // Done-qualified and field outputs hold across a rejected sentence.
    send_sentence("$GPGGA,9*00\r\n");
    drain("hold");
    check("hold_count", o_field_count, 2);
    check("hold_cksum_ok", o_cksum_ok, 1);
    check("hold_data", o_field_data, 96'h4E);
    check("hold_len", o_field_len, 1);

    // Reset in the middle of a field.
    send_sentence("$GPGLL,12");
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midreset_flags", {o_field_valid, o_field_idx, o_field_len, o_field_trunc,
                             o_sentence_done, o_cksum_ok, o_field_count, o_overflow}, 0);
    check("midreset_data", o_field_data, 0);
    @(negedge clk);
    rst = 1'b1;
    send_sentence(",N*2F\r\n");
    drain("after_reset_tail");
    check("after_reset_count", o_field_count, 0);

    push_fields("1|N");
    push_done(1'b1, 2, 1'b0);
    send_sentence("$GPGLL,1,N*2F\r\n");
    drain("after_reset_fresh");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
